// File: rtl/spi_slave.sv
// spi_slave: SPI mode 0 (CPOL=0, CPHA=0) slave. It shifts MSB first and
// oversamples spi_clk, spi_cs and spi_mosi in the clk domain.
//
// Ports
//   clk          system clock; all state updates on the rising edge
//   reset        synchronous, active-high reset
//   spi_clk      serial clock from the master (asynchronous to clk)
//   spi_cs       chip select from the master, active low
//   spi_mosi     serial data from the master
//   spi_miso     serial data to the master (1 when not selected)
//   spi_miso_oe  MISO drive enable, high while selected
//   tx_data      word to return on the next transfer
//   tx_we        one-cycle write strobe for tx_data
//   tx_empty     transmit buffer free
//   rx_data      last complete received word
//   rx_valid     rx_data unread (sticky until rx_re)
//   rx_re        one-cycle read acknowledge
//   rx_overrun   sticky: a word completed while rx_valid was still set
//   irq          level interrupt, rx_valid | rx_overrun
module spi_slave #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              spi_clk,
  input  logic              spi_cs,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_we,
  output logic              tx_empty,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_re,
  output logic              rx_overrun,
  output logic              irq
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;

  // The three SPI inputs go through identical chains so their relative timing
  // is preserved. The chains reset to 0. As a result, a CS held low across reset
  // release shows no falling edge, and the slave waits for a fresh select.
  logic [2:0] raw_in;
  logic [2:0] sync_in;

  assign raw_in = {spi_clk, spi_cs, spi_mosi};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_sync
      logic [SYNC_STAGES-1:0] chain_reg;

      always_ff @(posedge clk) begin
        if (reset) begin
          chain_reg <= '0;
        end else begin
          chain_reg <= {chain_reg[SYNC_STAGES-2:0], raw_in[gi]};
        end
      end

      assign sync_in[gi] = chain_reg[SYNC_STAGES-1];
    end
  endgenerate

  logic sclk_s;
  logic cs_s;
  logic mosi_s;

  assign sclk_s = sync_in[2];
  assign cs_s   = sync_in[1];
  assign mosi_s = sync_in[0];

  logic sclk_prev_reg;
  logic cs_prev_reg;
  logic sclk_rise;
  logic sclk_fall;
  logic cs_fall;

  assign sclk_rise = sclk_s & ~sclk_prev_reg;
  assign sclk_fall = ~sclk_s & sclk_prev_reg;
  assign cs_fall   = ~cs_s & cs_prev_reg;

  logic [1:0]        state_reg;
  logic [CNT_W-1:0]  bit_cnt_reg;
  logic [DATA_W-1:0] tx_shift_reg;
  logic [DATA_W-1:0] rx_shift_reg;
  logic              word_done_reg;
  logic [DATA_W-1:0] tx_buf_reg;
  logic              tx_empty_reg;
  logic [DATA_W-1:0] rx_data_reg;
  logic              rx_valid_reg;
  logic              rx_overrun_reg;
  logic              load_now;

  assign load_now = (state_reg == LOAD);

  // Serial engine
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      bit_cnt_reg   <= '0;
      tx_shift_reg  <= '0;
      rx_shift_reg  <= '0;
      word_done_reg <= 1'b0;
      sclk_prev_reg <= 1'b0;
      cs_prev_reg   <= 1'b0;
    end else begin
      sclk_prev_reg <= sclk_s;
      cs_prev_reg   <= cs_s;
      word_done_reg <= 1'b0;

      if (cs_s) begin
        // Deselect drops any partial word; no completion is signalled.
        state_reg   <= IDLE;
        bit_cnt_reg <= '0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (cs_fall) begin
              state_reg <= LOAD;
            end
          end
          LOAD: begin
            tx_shift_reg <= tx_empty_reg ? {DATA_W{1'b1}} : tx_buf_reg;
            state_reg    <= SHIFT;
          end
          SHIFT: begin
            if (sclk_rise) begin
              rx_shift_reg <= {rx_shift_reg[DATA_W-2:0], mosi_s};
              if (bit_cnt_reg == LAST_BIT) begin
                bit_cnt_reg   <= '0;
                word_done_reg <= 1'b1;
                state_reg     <= LOAD;
              end else begin
                bit_cnt_reg <= bit_cnt_reg + 1'b1;
              end
            end else if (sclk_fall && (bit_cnt_reg != '0)) begin
              // A zero count means that no bit of the current word has been
              // sampled yet. The falling edge that follows the last bit is
              // skipped here, so the freshly loaded MSB stays on MISO.
              tx_shift_reg <= {tx_shift_reg[DATA_W-2:0], 1'b0};
            end
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  // Transmit buffer. A host write wins over a same-cycle LOAD. LOAD has
  // already sampled the old contents, so the new word stays pending.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_buf_reg   <= '0;
      tx_empty_reg <= 1'b1;
    end else if (tx_we) begin
      tx_buf_reg   <= tx_data;
      tx_empty_reg <= 1'b0;
    end else if (load_now) begin
      tx_empty_reg <= 1'b1;
    end
  end

  // Receive side. Word completion takes priority over a same-cycle read:
  // the read counts as consuming the old word, so no overrun is raised.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_data_reg    <= '0;
      rx_valid_reg   <= 1'b0;
      rx_overrun_reg <= 1'b0;
    end else if (word_done_reg) begin
      rx_data_reg  <= rx_shift_reg;
      rx_valid_reg <= 1'b1;
      if (rx_valid_reg && !rx_re) begin
        rx_overrun_reg <= 1'b1;
      end else if (rx_re) begin
        rx_overrun_reg <= 1'b0;
      end
    end else if (rx_re) begin
      rx_valid_reg   <= 1'b0;
      rx_overrun_reg <= 1'b0;
    end
  end

  assign spi_miso    = (state_reg == IDLE) ? 1'b1 : tx_shift_reg[DATA_W-1];
  assign spi_miso_oe = (state_reg != IDLE);
  assign tx_empty    = tx_empty_reg;
  assign rx_data     = rx_data_reg;
  assign rx_valid    = rx_valid_reg;
  assign rx_overrun  = rx_overrun_reg;
  assign irq         = rx_valid_reg | rx_overrun_reg;

endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: directed SPI mode 0 master with two scoreboard monitors.
// The first monitor collects the words the master shifts in on MISO. The
// second monitor compares each rx_valid/rx_overrun rise on the host side.
// Both monitors check against expectations queued by the stimulus.
module tb_spi_slave;

  localparam int HALF = 8;  // clk cycles per SPI half period (clk/16)

  logic       clk      = 1'b0;
  logic       reset    = 1'b1;
  logic       spi_clk  = 1'b0;
  logic       spi_cs   = 1'b1;
  logic       spi_mosi = 1'b0;
  logic [7:0] tx_data  = 8'h00;
  logic       tx_we    = 1'b0;
  logic       rx_re    = 1'b0;
  logic       spi_miso;
  logic       spi_miso_oe;
  logic       tx_empty;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_overrun;
  logic       irq;

  spi_slave #(.DATA_W(8), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .spi_clk    (spi_clk),
    .spi_cs     (spi_cs),
    .spi_mosi   (spi_mosi),
    .spi_miso   (spi_miso),
    .spi_miso_oe(spi_miso_oe),
    .tx_data    (tx_data),
    .tx_we      (tx_we),
    .tx_empty   (tx_empty),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_re      (rx_re),
    .rx_overrun (rx_overrun),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] data;
    logic       ov;
  } rx_exp_t;

  rx_exp_t    rx_q[$];
  logic [7:0] miso_q[$];
  int         n_checks = 0;
  int         n_pass   = 0;
  int         lat      = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, got, exp);
  endtask

  task automatic exp_rx(input logic [7:0] d, input logic ov);
    rx_exp_t e;
    e.data = d;
    e.ov   = ov;
    rx_q.push_back(e);
  endtask

  task automatic tick_half();
    repeat (HALF) @(posedge clk);
    #1;
  endtask

  task automatic cs_low();
    @(posedge clk); #1;
    spi_cs = 1'b0;
    tick_half();
  endtask

  task automatic cs_high();
    tick_half();
    spi_cs = 1'b1;
    tick_half();
    tick_half();
  endtask

  task automatic send(input logic [7:0] w, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = w[7-i];
      tick_half();
      spi_clk = 1'b1;
      tick_half();
      spi_clk = 1'b0;
    end
  endtask

  task automatic write_tx(input logic [7:0] v);
    @(posedge clk); #1;
    tx_data = v;
    tx_we   = 1'b1;
    @(posedge clk); #1;
    tx_we   = 1'b0;
  endtask

  task automatic read_ack();
    @(posedge clk); #1;
    rx_re = 1'b1;
    @(posedge clk); #1;
    rx_re = 1'b0;
    @(posedge clk); #1;
  endtask

  // MISO monitor: this is the data the master shifts in on its rising edges.
  initial begin : miso_mon
    logic [7:0] acc;
    int         nb;
    acc = 8'h00;
    nb  = 0;
    forever begin
      @(posedge spi_clk or posedge spi_cs);
      if (spi_cs) begin
        nb  = 0;
        acc = 8'h00;
      end else begin
        acc = {acc[6:0], spi_miso};
        nb++;
        if (nb == 8) begin
          nb = 0;
          if (miso_q.size() == 0) begin
            n_checks++;
            $display("FAIL miso_unexpected: got word %h, expected no word", acc);
          end else begin
            logic [7:0] e;
            e = miso_q.pop_front();
            $display("spi xfer: master got %h, expected %h", acc, e);
            chk("miso_word", {24'h0, acc}, {24'h0, e});
          end
        end
      end
    end
  end

  // Host-side monitor: fires on any rise of rx_valid or rx_overrun.
  initial begin : rx_mon
    logic pv;
    logic po;
    pv = 1'b0;
    po = 1'b0;
    forever begin
      @(posedge clk); #1;
      if ((rx_valid === 1'b1 && !pv) || (rx_overrun === 1'b1 && !po)) begin
        if (rx_q.size() == 0) begin
          n_checks++;
          $display("FAIL rx_unexpected: got rx_data %h ov %b, expected no event", rx_data, rx_overrun);
        end else begin
          rx_exp_t e;
          e = rx_q.pop_front();
          $display("rx event: rx_data %h ov %b, expected %h ov %b", rx_data, rx_overrun, e.data, e.ov);
          chk("rx_data", {24'h0, rx_data}, {24'h0, e.data});
          chk("rx_overrun", {31'h0, rx_overrun}, {31'h0, e.ov});
        end
      end
      pv = (rx_valid === 1'b1);
      po = (rx_overrun === 1'b1);
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    // Reset state
    repeat (4) @(posedge clk);
    #1;
    chk("rst0_miso", spi_miso, 1);
    chk("rst0_oe", spi_miso_oe, 0);
    chk("rst0_valid", rx_valid, 0);
    chk("rst0_irq", irq, 0);
    chk("rst0_tx_empty", tx_empty, 1);
    chk("rst0_rx_data", rx_data, 0);
    reset = 1'b0;
    repeat (4) @(posedge clk);

    // Basic exchange: A5 out, 3C in. Also measure completion latency.
    write_tx(8'hA5);
    chk("t1_tx_full", tx_empty, 0);
    miso_q.push_back(8'hA5);
    exp_rx(8'h3C, 1'b0);
    cs_low();
    chk("t1_oe", spi_miso_oe, 1);
    fork
      send(8'h3C, 8);
      begin
        repeat (8) @(posedge spi_clk);
        lat = 0;
        while (rx_valid !== 1'b1 && lat < 64) begin
          @(posedge clk); #1;
          lat++;
        end
      end
    join
    chk("t1_valid_seen", rx_valid, 1);
    cs_high();
    chk("t1_rx_data", rx_data, 8'h3C);
    chk("t1_irq", irq, 1);
    chk("t1_tx_empty", tx_empty, 1);
    chk("t1_oe_idle", spi_miso_oe, 0);
    read_ack();
    chk("t1_valid_clr", rx_valid, 0);

    // Back-to-back words under one CS; second tx word written mid-transfer.
    write_tx(8'h12);
    miso_q.push_back(8'h12);
    miso_q.push_back(8'h34);
    exp_rx(8'h11, 1'b0);
    exp_rx(8'h22, 1'b1);
    cs_low();
    fork
      begin
        send(8'h11, 8);
        send(8'h22, 8);
      end
      begin
        repeat (2) @(posedge spi_clk);
        write_tx(8'h34);
      end
    join
    cs_high();
    chk("t2_rx_data", rx_data, 8'h22);
    chk("t2_overrun", rx_overrun, 1);
    read_ack();
    chk("t2_valid_clr", rx_valid, 0);
    chk("t2_ov_clr", rx_overrun, 0);
    chk("t2_irq_clr", irq, 0);

    // Empty buffer: master receives all ones.
    miso_q.push_back(8'hFF);
    exp_rx(8'hC3, 1'b0);
    cs_low();
    send(8'hC3, 8);
    cs_high();
    chk("t3_tx_empty", tx_empty, 1);
    read_ack();

    // Aborted 5-bit word, then a full word 81.
    cs_low();
    send(8'hF0, 5);
    cs_high();
    chk("t4_no_valid", rx_valid, 0);
    write_tx(8'h96);
    miso_q.push_back(8'h96);
    exp_rx(8'h81, 1'b0);
    cs_low();
    send(8'h81, 8);
    cs_high();
    chk("t4_rx_data", rx_data, 8'h81);

    // rx_re coincident with completion while rx_valid is still set.
    miso_q.push_back(8'hFF);
    cs_low();
    fork
      send(8'h6E, 8);
      begin
        repeat (8) @(posedge spi_clk);
        if (lat > 1) repeat (lat - 1) @(posedge clk);
        #1;
        rx_re = 1'b1;
        @(posedge clk); #1;
        rx_re = 1'b0;
      end
    join
    cs_high();
    chk("t5_valid", rx_valid, 1);
    chk("t5_overrun", rx_overrun, 0);
    chk("t5_rx_data", rx_data, 8'h6E);

    // Reset 3 bits into a word, with CS held low across reset release.
    write_tx(8'h55);
    cs_low();
    send(8'hE0, 3);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst1_miso", spi_miso, 1);
    chk("rst1_oe", spi_miso_oe, 0);
    chk("rst1_valid", rx_valid, 0);
    chk("rst1_overrun", rx_overrun, 0);
    chk("rst1_irq", irq, 0);
    chk("rst1_tx_empty", tx_empty, 1);
    chk("rst1_rx_data", rx_data, 0);
    reset = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("rst1_wait_fresh_cs", spi_miso_oe, 0);
    cs_high();
    miso_q.push_back(8'hFF);
    exp_rx(8'h5A, 1'b0);
    cs_low();
    chk("t6_oe", spi_miso_oe, 1);
    send(8'h5A, 8);
    cs_high();
    chk("t6_rx_data", rx_data, 8'h5A);

    repeat (8) @(posedge clk);
    #1;
    chk("miso_q_drained", miso_q.size(), 0);
    chk("rx_q_drained", rx_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
